// File: rtl/mem_bus_arbiter_pkg.sv
// Purpose: shared types and constants for the I/D cache memory-port arbiter.
// Contents: state encoding, one-hot grant encodings, default bus widths.
// Imported by mem_arb_pick and mem_bus_arbiter.
package mem_bus_arbiter_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int LINE_W_DEF = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // One-hot owner encodings: bit 0 = I-cache, bit 1 = D-cache.
  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_I    = 2'b01;
  localparam logic [1:0] GRANT_D    = 2'b10;

endpackage

// File: rtl/mem_arb_pick.sv
// Purpose: combinational 2-way picker choosing the I or D requester.
// Latency: purely combinational; no backpressure, result is only a suggestion.
// Ports: req[0]=I start, req[1]=D start, last_d=1 when D won the last tie; win is one-hot.
// Build option MEM_ARB_DCACHE_PRIO_EN: D always wins ties and last_d is ignored.
module mem_arb_pick
  import mem_bus_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_d,
  output logic [1:0] win
);

`ifdef MEM_ARB_DCACHE_PRIO_EN
  logic unused_last_d;
  assign unused_last_d = last_d;
`endif

  always_comb begin
    win = GRANT_NONE;
    case (req)
      2'b01:   win = GRANT_I;
      2'b10:   win = GRANT_D;
`ifdef MEM_ARB_DCACHE_PRIO_EN
      2'b11:   win = GRANT_D;
`else
      // Tie: whoever did not win the previous tie goes now.
      2'b11:   win = last_d ? GRANT_I : GRANT_D;
`endif
      default: win = GRANT_NONE;
    endcase
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Purpose: shares one line-read memory port between the I-cache and D-cache.
// Latency: start seen in cycle N drives registered mem_read_start/address in N+1.
// Backpressure: losing requester waits with start held; ready reaches only the owner.
// Ports: i_/d_ start+address in, rdy+data out; mem_* to memory; grant/busy/timeout_err status.
// Build option MEM_ARB_DCACHE_PRIO_EN: fixed D-over-I priority instead of round-robin.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int LINE_W         = LINE_W_DEF,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_address,
  output logic              i_rdy,
  output logic [LINE_W-1:0] i_data,
  input  logic              d_start,
  input  logic [ADDR_W-1:0] d_address,
  output logic              d_rdy,
  output logic [LINE_W-1:0] d_data,
  output logic [ADDR_W-1:0] mem_bus_address,
  output logic              mem_read_start,
  input  logic [LINE_W-1:0] mem_bus_data,
  input  logic              mem_read_rdy,
  output logic [1:0]        grant,
  output logic              busy,
  output logic              timeout_err
);

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state, state_nxt;
  logic [1:0]  win;
  logic        last_d;
  logic [15:0] count;
  logic        granted_start;

  // Line alignment drops the byte offset within a 16-byte line.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{i_address[3:0], d_address[3:0]};

  mem_arb_pick u_pick (
    .req    ({d_start, i_start}),
    .last_d (last_d),
    .win    (win)
  );

  assign granted_start = (grant[0] & i_start) | (grant[1] & d_start);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_start || d_start)                 state_nxt = GRANT;
      // A start dropped early is not an abort: leave only once data has come back.
      GRANT:   if (mem_read_rdy && !granted_start)     state_nxt = DRAIN;
      DRAIN:   if (!mem_read_rdy)                      state_nxt = IDLE;
      default:                                         state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      grant           <= GRANT_NONE;
      mem_read_start  <= 1'b0;
      mem_bus_address <= '0;
      count           <= '0;
      last_d          <= 1'b1;
      timeout_err     <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (state_nxt == GRANT) begin
            grant           <= win;
            mem_read_start  <= 1'b1;
            mem_bus_address <= {(win[1] ? d_address[ADDR_W-1:4] : i_address[ADDR_W-1:4]), 4'b0000};
            count           <= '0;
            // Only contested arbitrations move the round-robin pointer.
            if (i_start && d_start) last_d <= win[1];
          end
        end
        GRANT: begin
          if (state_nxt == DRAIN) begin
            mem_read_start <= 1'b0;
          end else if (!mem_read_rdy) begin
            if (count != 16'hFFFF) count <= count + 16'd1;
            if (count == TO_LAST)  timeout_err <= 1'b1;
          end
        end
        DRAIN: begin
          if (state_nxt == IDLE) grant <= GRANT_NONE;
        end
        default: grant <= GRANT_NONE;
      endcase
    end
  end

  assign i_rdy  = mem_read_rdy & grant[0];
  assign d_rdy  = mem_read_rdy & grant[1];
  assign i_data = mem_bus_data;
  assign d_data = mem_bus_data;
  assign busy   = (state != IDLE);

endmodule
